cam_init_seq: RTL and testbench
===============================

CAM_INIT_SEQ -- requirements
Module: cam_init_seq

Interface
REQ-001 SHALL have parameter CLK_F, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter ROM_AW, default 8, table address width.
REQ-003 SHALL have parameter REG_AW, default 8, sensor register address width.
REQ-004 SHALL have parameter REG_DW, default 8, sensor register data width.
REQ-005 SHALL have parameter DEV_ID, default 8'h42, 8-bit SCCB device write address.
REQ-006 SHALL have parameter MAX_RETRY, default 3, re-issues allowed per entry after a NACK.
REQ-007 SHALL have parameter DELAY_UNIT_US, default 1000, microseconds per delay-entry count.
REQ-008 SHALL have port i_clk, input, 1, the single clock.
REQ-009 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have ports i_start (input, 1, begin sequence) and i_abort (input, 1, stop sequence).
REQ-011 SHALL have ports o_rom_addr (output, ROM_AW) and i_rom_data (input, REG_AW+REG_DW, {addr,data}); the ROM is synchronous with 1-cycle latency.
REQ-012 SHALL have ports o_sccb_start (output, 1), o_sccb_rw (output, 1, 0=write), o_sccb_dev (output, 8), o_sccb_addr (output, REG_AW), o_sccb_wdata (output, REG_DW).
REQ-013 SHALL have ports i_sccb_ready, i_sccb_done and i_sccb_ack (input, 1 each), and i_sccb_rdata (input, REG_DW).
REQ-014 SHALL have outputs o_busy (1), o_done (1), o_error (1), o_err_index (ROM_AW) and o_mismatch_cnt (ROM_AW).

Function
REQ-015 FSM states SHALL be IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE and ERROR.
REQ-016 i_start in IDLE, DONE or ERROR SHALL clear o_done, o_error and o_mismatch_cnt, load index 0 and enter FETCH; i_start is ignored in all other states.
REQ-017 FETCH SHALL drive o_rom_addr=index and hold one cycle; DECODE SHALL classify the registered i_rom_data.
REQ-018 Entry with addr all-ones and data all-ones SHALL be END; transition to DONE and assert o_done until the next i_start.
REQ-019 Entry with addr all-ones and data not all-ones SHALL be DELAY, waiting data*DELAY_UNIT_US*CLK_F/1e6 cycles (timer width computed from parameters, no overflow at data max); data=0 SHALL advance immediately.
REQ-020 Any other entry SHALL be a WRITE: in ISSUE, o_sccb_start is pulsed for exactly one cycle, only in a cycle where i_sccb_ready=1, with o_sccb_dev=DEV_ID, o_sccb_rw=0 and addr/data fields stable from the pulse until i_sccb_done.
REQ-021 In WAIT, on i_sccb_done with i_sccb_ack=1, index SHALL increment and the FSM SHALL return to FETCH.
REQ-022 On a NACK (i_sccb_done with ack=0), the entry SHALL be re-issued up to MAX_RETRY times; the retry counter resets per entry; when exhausted, the FSM SHALL enter ERROR with o_error=1 and o_err_index=index.
REQ-023 Index wrap (ROM_AW all-ones reached without END) SHALL enter ERROR with o_err_index=all-ones.
REQ-024 i_abort SHALL take priority over all other events: in WAIT, the FSM first waits for i_sccb_done (no bus truncation), then goes to IDLE; in other states it goes to IDLE next cycle; o_done stays 0.
REQ-025 o_busy SHALL be 1 in every state except IDLE, DONE and ERROR.

Reset
REQ-026 Asserting i_rst_n=0 SHALL asynchronously force IDLE, index 0, counters 0, and all outputs 0 except o_sccb_dev=DEV_ID; reset mid-transaction SHALL abandon it without a further o_sccb_start.

Configuration
REQ-027 With macro CAM_INIT_READBACK_EN defined, each acked WRITE SHALL be followed by a read (o_sccb_rw=1, same address) using a single read attempt; if i_sccb_rdata differs from the written data, o_mismatch_cnt SHALL increment (saturating) and the sequence SHALL continue; a NACK on the read SHALL follow REQ-022.
REQ-028 Without the macro, no reads SHALL be issued and o_mismatch_cnt SHALL be tied to 0.

Verification
REQ-029 Table {12'h1280, 16'h1100, FFFF}, always ack -> exactly 2 write pulses, addr 12/11 data 80/00, o_done=1, o_error=0.
REQ-030 Table {12'h1280, FF0A, FFFF}, CLK_F=1e6, DELAY_UNIT_US=1000 -> 10_000 cycles ±2 between first done and o_done.
REQ-031 NACK for entry 1 four times with MAX_RETRY=3 -> 4 pulses on that entry, o_error=1, o_err_index=1, busy=0.
REQ-032 i_abort raised during WAIT -> no further start pulses after i_sccb_done, state IDLE, o_done=0; a new i_start reruns from index 0.
REQ-033 i_sccb_ready held low for 50 cycles in ISSUE -> no start pulse until ready=1; i_rst_n pulse mid-WAIT -> all outputs 0 immediately.
REQ-034 With CAM_INIT_READBACK_EN defined, write 12'h1280 and return rdata 8'h00 -> one read pulse (rw=1, addr 12), o_mismatch_cnt=1, o_done=1.

Source files
------------

// File: rtl/cam_init_seq.sv
// cam_init_seq: walks a ROM table of {reg_addr, reg_data} entries and programs a
// camera sensor over an SCCB master. Table entry kinds:
//   addr all-ones, data all-ones  -> END (sequence complete)
//   addr all-ones, data N         -> DELAY of N * DELAY_UNIT_US microseconds
//   anything else                 -> register WRITE, re-issued on NACK up to MAX_RETRY times
// Optional feature: define CAM_INIT_READBACK_EN to read back every acked write and
// count data mismatches in o_mismatch_cnt (tied to 0 otherwise).
module cam_init_seq #(
    parameter int         CLK_F         = 100_000_000,
    parameter int         ROM_AW        = 8,
    parameter int         REG_AW        = 8,
    parameter int         REG_DW        = 8,
    parameter logic [7:0] DEV_ID        = 8'h42,
    parameter int         MAX_RETRY     = 3,
    parameter int         DELAY_UNIT_US = 1000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    output logic [ROM_AW-1:0]        o_rom_addr,
    input  logic [REG_AW+REG_DW-1:0] i_rom_data,
    output logic                     o_sccb_start,
    output logic                     o_sccb_rw,
    output logic [7:0]               o_sccb_dev,
    output logic [REG_AW-1:0]        o_sccb_addr,
    output logic [REG_DW-1:0]        o_sccb_wdata,
    input  logic                     i_sccb_ready,
    input  logic                     i_sccb_done,
    input  logic                     i_sccb_ack,
    input  logic [REG_DW-1:0]        i_sccb_rdata,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic [ROM_AW-1:0]        o_err_index,
    output logic [ROM_AW-1:0]        o_mismatch_cnt
);

    // Delay timer sizing, done in 64 bits so DELAY_UNIT_US * CLK_F cannot overflow.
    localparam longint unsigned DU           = longint'(DELAY_UNIT_US);
    localparam longint unsigned CF           = longint'(CLK_F);
    localparam longint unsigned CYC_PER_UNIT = (DU * CF) / 64'd1_000_000;
    localparam longint unsigned DLY_MAX      = CYC_PER_UNIT * ((64'd1 << REG_DW) - 64'd1);
    localparam int              TMR_W        = (DLY_MAX < 64'd2) ? 1 : $clog2(DLY_MAX + 64'd1);
    // Fetch/decode of the delay entry and of the entry after it take cycles of their
    // own; trimming them from the load keeps the observed pause close to nominal.
    localparam longint unsigned DLY_ADJ      = 64'd4;
    localparam int              RC_W         = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE, ERROR
    } state_t;

    state_t            state;
    logic [ROM_AW-1:0] idx;
    logic [TMR_W-1:0]  timer;
    logic [RC_W-1:0]   retry_cnt;
    logic              abort_pend;

    logic [REG_AW-1:0] rom_reg;
    logic [REG_DW-1:0] rom_val;
    logic [63:0]       dly_full;
    logic [63:0]       dly_load;

    assign {rom_reg, rom_val} = i_rom_data;
    assign o_rom_addr         = idx;
    assign o_sccb_dev         = DEV_ID;
    assign o_busy             = !(state == IDLE || state == DONE || state == ERROR);
    // Start is qualified by ready in the same cycle so a pulse never lands while the
    // master is busy; a pending abort suppresses it so nothing is launched.
    assign o_sccb_start       = (state == ISSUE) && i_sccb_ready && !i_abort;

`ifdef CAM_INIT_READBACK_EN
    logic              rd_phase;
    logic [ROM_AW-1:0] mism_q;
    assign o_mismatch_cnt = mism_q;
`else
    logic rdata_unused;
    assign rdata_unused   = ^i_sccb_rdata;
    assign o_mismatch_cnt = '0;
`endif

    // Delay length in cycles for the entry currently on the ROM bus, never below 1.
    always_comb begin
        dly_full = 64'(rom_val) * CYC_PER_UNIT;
        dly_load = (dly_full > DLY_ADJ) ? (dly_full - DLY_ADJ) : 64'd1;
    end

    // Sequencer: table walk, SCCB handshake, retries, delays, abort and error handling.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            timer        <= '0;
            retry_cnt    <= '0;
            abort_pend   <= 1'b0;
            o_sccb_rw    <= 1'b0;
            o_sccb_addr  <= '0;
            o_sccb_wdata <= '0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_err_index  <= '0;
`ifdef CAM_INIT_READBACK_EN
            rd_phase     <= 1'b0;
            mism_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (i_start && !i_abort) begin
                        o_done      <= 1'b0;
                        o_error     <= 1'b0;
                        o_err_index <= '0;
                        idx         <= '0;
                        abort_pend  <= 1'b0;
                        state       <= FETCH;
`ifdef CAM_INIT_READBACK_EN
                        mism_q      <= '0;
`endif
                    end
                end
                FETCH: begin
                    // ROM address is already idx; data shows up next cycle.
                    state <= i_abort ? IDLE : DECODE;
                end
                DECODE: begin
                    if (i_abort) begin
                        state <= IDLE;
                    end else begin
                        retry_cnt <= '0;
                        o_sccb_rw <= 1'b0;
`ifdef CAM_INIT_READBACK_EN
                        rd_phase  <= 1'b0;
`endif
                        if (rom_reg == '1) begin
                            if (rom_val == '1) begin
                                state  <= DONE;
                                o_done <= 1'b1;
                            end else if (rom_val == '0) begin
                                if (idx == '1) begin
                                    state       <= ERROR;
                                    o_error     <= 1'b1;
                                    o_err_index <= '1;
                                end else begin
                                    idx   <= idx + 1'b1;
                                    state <= FETCH;
                                end
                            end else begin
                                timer <= TMR_W'(dly_load);
                                state <= DELAY;
                            end
                        end else begin
                            o_sccb_addr  <= rom_reg;
                            o_sccb_wdata <= rom_val;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (i_abort)
                        state <= IDLE;
                    else if (i_sccb_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    // An abort here is remembered; the bus transfer always finishes.
                    if (i_abort)
                        abort_pend <= 1'b1;
                    if (i_sccb_done) begin
                        if (abort_pend || i_abort) begin
                            abort_pend <= 1'b0;
                            state      <= IDLE;
                        end else if (i_sccb_ack) begin
`ifdef CAM_INIT_READBACK_EN
                            if (!rd_phase) begin
                                rd_phase  <= 1'b1;
                                o_sccb_rw <= 1'b1;
                                state     <= ISSUE;
                            end else begin
                                if (i_sccb_rdata != o_sccb_wdata && mism_q != '1)
                                    mism_q <= mism_q + 1'b1;
                                if (idx == '1) begin
                                    state       <= ERROR;
                                    o_error     <= 1'b1;
                                    o_err_index <= '1;
                                end else begin
                                    idx   <= idx + 1'b1;
                                    state <= FETCH;
                                end
                            end
`else
                            if (idx == '1) begin
                                state       <= ERROR;
                                o_error     <= 1'b1;
                                o_err_index <= '1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= FETCH;
                            end
`endif
                        end else if (retry_cnt < RC_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ISSUE;
                        end else begin
                            state       <= ERROR;
                            o_error     <= 1'b1;
                            o_err_index <= idx;
                        end
                    end
                end
                DELAY: begin
                    if (i_abort) begin
                        state <= IDLE;
                    end else if (timer <= TMR_W'(1)) begin
                        if (idx == '1) begin
                            state       <= ERROR;
                            o_error     <= 1'b1;
                            o_err_index <= '1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_init_seq.sv
// Directed bench for cam_init_seq: behavioural ROM and SCCB master models, one task
// per scenario. Readback checks are compiled in when CAM_INIT_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_cam_init_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_q = 16'h0;
    logic        sccb_start, sccb_rw;
    logic [7:0]  sccb_dev, sccb_addr, sccb_wdata;
    logic        sccb_ready;
    logic        sccb_done = 1'b0;
    logic        sccb_ack = 1'b0;
    logic [7:0]  sccb_rdata = 8'h0;
    logic        busy, done, error;
    logic [7:0]  err_index, mismatch_cnt;

    logic [15:0] rom [0:255];

    // SCCB master model state and logs
    logic        ready_en = 1'b1;
    logic        tb_clr = 1'b0;
    int          sl_latency = 3;
    logic [7:0]  nack_addr = 8'h00;
    int          nack_limit = 0;
    logic [7:0]  force_rd = 8'h00;
    logic        force_rd_en = 1'b0;
    logic        sl_busy = 1'b0;
    int          sl_cnt = 0;
    logic        sl_rw = 1'b0;
    logic [7:0]  sl_addr = 8'h0, sl_wdata = 8'h0;
    logic [7:0]  smem [0:255];
    int          nack_given = 0;
    int          w_cnt = 0, r_cnt = 0;
    logic [7:0]  w_addr [0:63];
    logic [7:0]  w_data [0:63];
    logic [7:0]  r_addr [0:63];
    int          viol = 0, stab_err = 0;
    int          cyc = 0, last_done_cyc = 0;

    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    cam_init_seq #(.CLK_F(1_000_000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_rom_addr(rom_addr), .i_rom_data(rom_q),
        .o_sccb_start(sccb_start), .o_sccb_rw(sccb_rw), .o_sccb_dev(sccb_dev),
        .o_sccb_addr(sccb_addr), .o_sccb_wdata(sccb_wdata),
        .i_sccb_ready(sccb_ready), .i_sccb_done(sccb_done), .i_sccb_ack(sccb_ack),
        .i_sccb_rdata(sccb_rdata),
        .o_busy(busy), .o_done(done), .o_error(error),
        .o_err_index(err_index), .o_mismatch_cnt(mismatch_cnt)
    );

    // Synchronous ROM, one cycle latency
    always @(posedge clk) rom_q <= rom[rom_addr];

    assign sccb_ready = ready_en && !sl_busy;

    // SCCB master model: accepts a start, answers after sl_latency cycles
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        sccb_done <= 1'b0;
        if (sl_busy) begin
            if (sl_cnt == 0) begin
                sl_busy       <= 1'b0;
                sccb_done     <= 1'b1;
                last_done_cyc <= cyc;
                if (busy && (sccb_addr != sl_addr || sccb_wdata != sl_wdata || sccb_rw != sl_rw))
                    stab_err <= stab_err + 1;
                if (!sl_rw && sl_addr == nack_addr && nack_given < nack_limit) begin
                    sccb_ack   <= 1'b0;
                    nack_given <= nack_given + 1;
                end else begin
                    sccb_ack <= 1'b1;
                    if (!sl_rw) smem[sl_addr] <= sl_wdata;
                    sccb_rdata <= force_rd_en ? force_rd : smem[sl_addr];
                end
            end else begin
                sl_cnt <= sl_cnt - 1;
            end
        end
        if (sccb_start) begin
            if (!sccb_ready) viol <= viol + 1;
            sl_busy  <= 1'b1;
            sl_cnt   <= sl_latency;
            sl_rw    <= sccb_rw;
            sl_addr  <= sccb_addr;
            sl_wdata <= sccb_wdata;
            if (!sccb_rw) begin
                if (w_cnt < 64) begin
                    w_addr[w_cnt] <= sccb_addr;
                    w_data[w_cnt] <= sccb_wdata;
                end
                w_cnt <= w_cnt + 1;
            end else begin
                if (r_cnt < 64) r_addr[r_cnt] <= sccb_addr;
                r_cnt <= r_cnt + 1;
            end
        end
        if (tb_clr) begin
            w_cnt      <= 0;
            r_cnt      <= 0;
            nack_given <= 0;
        end
    end

    task automatic set_rom(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
    endtask

    task automatic clr();
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_writes(input int k, input int budget);
        int n;
        n = 0;
        while (w_cnt < k && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", error); end
        checks++; if (sccb_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b want 0", sccb_start); end
        checks++; if (sccb_dev !== 8'h42) begin errors++; $display("FAIL reset_dev: got %0h want 42", sccb_dev); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %0h want 0", rom_addr); end
        checks++; if (err_index !== 8'h00 || mismatch_cnt !== 8'h00) begin errors++;
            $display("FAIL reset_counts: got err_index=%0h mism=%0h want 0/0", err_index, mismatch_cnt); end
    endtask

    task automatic test_write_seq();
        set_rom(16'h1280, 16'h1100, 16'hFFFF);
        clr();
        do_start();
        wait_idle(500);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_timeout: busy got %0b want 0", busy); end
        checks++; if (w_cnt !== 2) begin errors++; $display("FAIL wr_count: got %0d want 2", w_cnt); end
        checks++; if (w_addr[0] !== 8'h12 || w_data[0] !== 8'h80) begin errors++;
            $display("FAIL wr_entry0: got %0h/%0h want 12/80", w_addr[0], w_data[0]); end
        checks++; if (w_addr[1] !== 8'h11 || w_data[1] !== 8'h00) begin errors++;
            $display("FAIL wr_entry1: got %0h/%0h want 11/00", w_addr[1], w_data[1]); end
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++;
            $display("FAIL wr_status: got done=%0b error=%0b want 1/0", done, error); end
`ifndef CAM_INIT_READBACK_EN
        checks++; if (r_cnt !== 0 || mismatch_cnt !== 8'h00) begin errors++;
            $display("FAIL wr_no_read: got reads=%0d mism=%0h want 0/0", r_cnt, mismatch_cnt); end
`endif
    endtask

    task automatic test_delay();
        int n, diff;
        set_rom(16'h1280, 16'hFF0A, 16'hFFFF);
        clr();
        do_start();
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        diff = cyc - last_done_cyc - 1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dly_done: got %0b want 1", done); end
        checks++; if (diff < 9998 || diff > 10002) begin errors++;
            $display("FAIL dly_cycles: got %0d want 10000 +-2", diff); end
        checks++; if (w_cnt !== 1) begin errors++; $display("FAIL dly_writes: got %0d want 1", w_cnt); end
    endtask

    task automatic test_nack();
        int hits;
        set_rom(16'h1280, 16'h1100, 16'hFFFF);
        nack_addr = 8'h11;
        nack_limit = 4;
        clr();
        do_start();
        wait_idle(1000);
        hits = 0;
        for (int i = 0; i < w_cnt && i < 64; i++) if (w_addr[i] == 8'h11) hits++;
        checks++; if (hits !== 4) begin errors++; $display("FAIL nack_pulses: got %0d want 4", hits); end
        checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++;
            $display("FAIL nack_status: got error=%0b done=%0b want 1/0", error, done); end
        checks++; if (err_index !== 8'h01) begin errors++; $display("FAIL nack_index: got %0h want 1", err_index); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy: got %0b want 0", busy); end
        // Two NACKs then an ACK must recover within the retry budget
        nack_limit = 2;
        clr();
        do_start();
        wait_idle(1000);
        hits = 0;
        for (int i = 0; i < w_cnt && i < 64; i++) if (w_addr[i] == 8'h11) hits++;
        checks++; if (hits !== 3) begin errors++; $display("FAIL retry_pulses: got %0d want 3", hits); end
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++;
            $display("FAIL retry_status: got done=%0b error=%0b want 1/0", done, error); end
        nack_limit = 0;
    endtask

    task automatic test_abort();
        set_rom(16'h1280, 16'h1100, 16'hFFFF);
        sl_latency = 20;
        clr();
        do_start();
        wait_writes(1, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_holds: busy got %0b want 1", busy); end
        wait_idle(200);
        checks++; if (sl_busy !== 1'b0) begin errors++; $display("FAIL abort_truncated: bus busy got %0b want 0", sl_busy); end
        repeat (30) @(negedge clk);
        checks++; if (w_cnt !== 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", w_cnt); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL abort_state: got busy=%0b done=%0b want 0/0", busy, done); end
        sl_latency = 3;
        clr();
        do_start();
        wait_idle(500);
        checks++; if (w_cnt !== 2 || w_addr[0] !== 8'h12) begin errors++;
            $display("FAIL abort_rerun: got n=%0d first=%0h want 2/12", w_cnt, w_addr[0]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_rerun_done: got %0b want 1", done); end
    endtask

    task automatic test_ready_stall();
        set_rom(16'h1280, 16'h1100, 16'hFFFF);
        ready_en = 1'b0;
        clr();
        do_start();
        repeat (50) @(negedge clk);
        checks++; if (w_cnt !== 0 || busy !== 1'b1) begin errors++;
            $display("FAIL stall_pulses: got n=%0d busy=%0b want 0/1", w_cnt, busy); end
        ready_en = 1'b1;
        wait_idle(500);
        checks++; if (w_cnt !== 2 || done !== 1'b1) begin errors++;
            $display("FAIL stall_resume: got n=%0d done=%0b want 2/1", w_cnt, done); end
        checks++; if (viol !== 0 || stab_err !== 0) begin errors++;
            $display("FAIL bus_rules: got ready_viol=%0d unstable=%0d want 0/0", viol, stab_err); end
    endtask

    task automatic test_reset_mid();
        set_rom(16'h1280, 16'h1100, 16'hFFFF);
        sl_latency = 20;
        clr();
        do_start();
        wait_writes(1, 100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || sccb_start !== 1'b0) begin errors++;
            $display("FAIL rstmid_busy: got busy=%0b start=%0b want 0/0", busy, sccb_start); end
        checks++; if (sccb_addr !== 8'h00 || sccb_wdata !== 8'h00 || rom_addr !== 8'h00) begin errors++;
            $display("FAIL rstmid_fields: got %0h/%0h/%0h want 0/0/0", sccb_addr, sccb_wdata, rom_addr); end
        checks++; if (done !== 1'b0 || error !== 1'b0 || sccb_dev !== 8'h42) begin errors++;
            $display("FAIL rstmid_flags: got done=%0b err=%0b dev=%0h want 0/0/42", done, error, sccb_dev); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (w_cnt !== 1 || busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_abandon: got n=%0d busy=%0b want 1/0", w_cnt, busy); end
        sl_latency = 3;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFF00;
        clr();
        do_start();
        wait_idle(2000);
        checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++;
            $display("FAIL wrap_status: got error=%0b done=%0b want 1/0", error, done); end
        checks++; if (err_index !== 8'hFF) begin errors++; $display("FAIL wrap_index: got %0h want ff", err_index); end
    endtask

`ifdef CAM_INIT_READBACK_EN
    task automatic test_readback();
        set_rom(16'h1280, 16'hFFFF, 16'hFFFF);
        force_rd = 8'h00;
        force_rd_en = 1'b1;
        clr();
        do_start();
        wait_idle(500);
        checks++; if (r_cnt !== 1 || r_addr[0] !== 8'h12) begin errors++;
            $display("FAIL rb_read: got n=%0d addr=%0h want 1/12", r_cnt, r_addr[0]); end
        checks++; if (mismatch_cnt !== 8'h01) begin errors++; $display("FAIL rb_mismatch: got %0h want 1", mismatch_cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rb_done: got %0b want 1", done); end
        force_rd_en = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) smem[i] = 8'h00;
        set_rom(16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_write_seq();
        test_delay();
        test_nack();
        test_abort();
        test_ready_stall();
        test_reset_mid();
        test_wrap();
`ifdef CAM_INIT_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
